// File: rtl/nn_arch_pkg.sv
// Shared architecture types for the two-layer MLP: output-layer size, logit type,
// class index type and the inference sequencer state encoding.
package nn_arch_pkg;

  localparam int OUTPUT_SIZE = 10;
  localparam int ACC_W       = 16;
  localparam int CLS_W       = $clog2(OUTPUT_SIZE);

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic [CLS_W-1:0]        cls_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN_HID,
    RUN_OUT,
    ARGMAX,
    RESP
  } ctrl_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mlp_infer_ctrl_if.sv
// Request/response handshake bundle of the inference sequencer.
// master = requester side, slave = mlp_infer_ctrl.
interface mlp_infer_ctrl_if;
  import nn_arch_pkg::*;

  logic     req_valid;
  logic     req_ready;
  logic     rsp_valid;
  logic     rsp_ready;
  cls_idx_t rsp_class;
  acc_t     rsp_max;
  logic     rsp_err;

  modport master (
    output req_valid, rsp_ready,
    input  req_ready, rsp_valid, rsp_class, rsp_max, rsp_err
  );

  modport slave (
    input  req_valid, rsp_ready,
    output req_ready, rsp_valid, rsp_class, rsp_max, rsp_err
  );

endinterface

// File: rtl/mlp_infer_ctrl_seq_argmax.sv
// Serial argmax over the output logits: load seeds with logits[0], each step
// compares one further logit; done flags the step that handles the last index.
module seq_argmax
  import nn_arch_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  logic     step,
  input  acc_t     logits [OUTPUT_SIZE],
  output acc_t     best,
  output cls_idx_t best_idx,
  output logic     done
);

  localparam cls_idx_t LAST_IDX = cls_idx_t'(OUTPUT_SIZE - 1);

  cls_idx_t idx;

  assign done = step && (idx == LAST_IDX);

  // NOTE: registers are written with <= so each compare sees the pre-edge best value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best     <= '0;
      best_idx <= '0;
      idx      <= '0;
    end else if (load) begin
      best     <= logits[0];
      best_idx <= '0;
      idx      <= cls_idx_t'(1);
    end else if (step) begin
      // Strict greater-than keeps the lowest index on ties.
      if (logits[idx] > best) begin
        best     <= logits[idx];
        best_idx <= idx;
      end
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/mlp_infer_ctrl.sv
// Inference sequencer: hidden core, output core, serial argmax, response with watchdog.
// Optional cycle counter enabled by defining MLP_CTRL_PERF_EN.
module mlp_infer_ctrl
  import nn_arch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                clk,
  input  logic                rst,
  mlp_infer_ctrl_if.slave     bus,
  output logic                hid_start,
  input  logic                hid_finished,
  output logic                out_start,
  input  logic                out_finished,
  input  acc_t                logits [OUTPUT_SIZE],
  output logic                busy
`ifdef MLP_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_cycles
`endif
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  if (OUTPUT_SIZE < 2) begin : g_size_check
    $error("mlp_infer_ctrl: OUTPUT_SIZE must be >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("mlp_infer_ctrl: TIMEOUT_CYCLES must be >= 2");
  end

  ctrl_state_t     state;
  logic [WD_W-1:0] wdog;
  logic            timed_out;
  logic            accept;
  logic            wd_expired;
  logic            scan_load;
  logic            scan_step;
  logic            scan_done;
  acc_t            best;
  cls_idx_t        best_idx;

  assign accept     = (state == IDLE) && bus.req_valid && bus.req_ready;
  assign wd_expired = (wdog == WD_LAST);
  assign scan_load  = (state == RUN_OUT) && out_finished;
  assign scan_step  = (state == ARGMAX);

  seq_argmax u_argmax (
    .clk      (clk),
    .rst      (rst),
    .load     (scan_load),
    .step     (scan_step),
    .logits   (logits),
    .best     (best),
    .best_idx (best_idx),
    .done     (scan_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wdog          <= '0;
      timed_out     <= 1'b0;
      hid_start     <= 1'b0;
      out_start     <= 1'b0;
      busy          <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_class <= '0;
      bus.rsp_max   <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      hid_start <= 1'b0;
      out_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state         <= RUN_HID;
            hid_start     <= 1'b1;
            wdog          <= '0;
            timed_out     <= 1'b0;
            busy          <= 1'b1;
            bus.req_ready <= 1'b0;
          end
        end
        RUN_HID: begin
          // A finished pulse on the expiry cycle still counts as success.
          if (hid_finished) begin
            state     <= RUN_OUT;
            out_start <= 1'b1;
            wdog      <= '0;
          end else if (wd_expired) begin
            state     <= RESP;
            timed_out <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RUN_OUT: begin
          if (out_finished) begin
            state <= ARGMAX;
          end else if (wd_expired) begin
            state     <= RESP;
            timed_out <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        ARGMAX: begin
          if (scan_done) state <= RESP;
        end
        RESP: begin
          if (!bus.rsp_valid) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= timed_out;
            bus.rsp_class <= timed_out ? '0 : best_idx;
            bus.rsp_max   <= timed_out ? '0 : best;
          end else if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MLP_CTRL_PERF_EN
  logic [31:0] perf_cnt;
  logic [31:0] perf_nxt;
  logic        to_resp;

  assign perf_nxt = sat_inc32(perf_cnt);
  assign to_resp  = ((state == RUN_HID) && !hid_finished && wd_expired) ||
                    ((state == RUN_OUT) && !out_finished && wd_expired) ||
                    ((state == ARGMAX)  && scan_done);

  // Seeded with 2 (accept cycle + response register) so the latched value
  // equals the accept-to-rsp_valid latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else if (accept) begin
      perf_cnt <= 32'd2;
    end else if (state inside {RUN_HID, RUN_OUT, ARGMAX}) begin
      perf_cnt <= perf_nxt;
      if (to_resp) perf_cycles <= perf_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mlp_infer_ctrl.sv
// Self-checking bench for mlp_infer_ctrl: a cycle-timeline model derived from the
// latency/timeout rules, checked every cycle, plus hand-computed literal results.
module tb_mlp_infer_ctrl;
  import nn_arch_pkg::*;

  localparam int TO = 64;
  localparam int N  = OUTPUT_SIZE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mlp_infer_ctrl_if bus ();
  logic hid_start, hid_finished, out_start, out_finished, busy;
  acc_t logits [N];
`ifdef MLP_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  mlp_infer_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .hid_start    (hid_start),
    .hid_finished (hid_finished),
    .out_start    (out_start),
    .out_finished (out_finished),
    .logits       (logits),
    .busy         (busy)
`ifdef MLP_CTRL_PERF_EN
    ,
    .perf_cycles  (perf_cycles)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Timeline model of the current transaction (absolute cycle numbers).
  int   m_acc = -100, m_hid = -100, m_out = -100, m_rv = -100, m_hs = -100;
  int   m_cls = 0, m_max = 0;
  logic m_err = 1'b0;
  bit   chk_en = 1'b0;
  bit   e_busy, e_rv;
  int   lv [N];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void model_argmax(output int cls, output int mx);
    cls = 0;
    mx  = int'(logits[0]);
    for (int i = 1; i < N; i++) begin
      if (int'(logits[i]) > mx) begin
        mx  = int'(logits[i]);
        cls = i;
      end
    end
  endfunction

  task automatic set_logits(input int v [N]);
    foreach (logits[i]) logits[i] = acc_t'(v[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      e_busy = (cyc > m_acc) && (cyc <= m_hs);
      e_rv   = (cyc >= m_rv) && (cyc <= m_hs);
      check("busy", busy, e_busy);
      check("req_ready", bus.req_ready, !e_busy);
      check("hid_start", hid_start, cyc == m_hid);
      check("out_start", out_start, cyc == m_out);
      check("rsp_valid", bus.rsp_valid, e_rv);
      if (e_rv) begin
        check("rsp_class", bus.rsp_class, m_cls);
        check("rsp_max", bus.rsp_max, m_max);
        check("rsp_err", bus.rsp_err, m_err);
      end
`ifdef MLP_CTRL_PERF_EN
      if (cyc == m_rv) check("perf_cycles", perf_cycles, m_rv - m_acc);
`endif
    end
  end

  // One transaction; t_h/t_o < 0 means that core never finishes. Entered and
  // left just after a rising edge; the request is accepted in the entry cycle.
  task automatic do_txn(input int t_h, input int t_o, input int stall, input bit hold_req,
                        input int late_hf, input int rst_at,
                        input int lit_cls, input int lit_max, input int lit_err);
    int hf_cyc, of_cyc, last_c;
    hf_cyc = -100;
    of_cyc = -100;
    bus.req_valid = 1'b1;
    m_acc = cyc;
    m_hid = cyc + 1;
    m_out = -100;
    if (t_h < 0) begin
      m_rv  = m_hid + TO + 1;
      m_err = 1'b1;
    end else begin
      hf_cyc = m_hid + t_h;
      m_out  = hf_cyc + 1;
      if (t_o < 0) begin
        m_rv  = m_out + TO + 1;
        m_err = 1'b1;
      end else begin
        of_cyc = m_out + t_o;
        m_rv   = m_acc + 2 + t_h + 1 + t_o + (N - 1) + 1;
        m_err  = 1'b0;
      end
    end
    if (m_err) begin
      m_cls = 0;
      m_max = 0;
    end else begin
      model_argmax(m_cls, m_max);
    end
    m_hs   = m_rv + stall;
    last_c = m_hs + 1;
    for (int c = m_acc + 1; c <= last_c; c++) begin
      @(posedge clk);
      #1;
      if (!hold_req) bus.req_valid = 1'b0;
      if (rst_at >= 0 && c == m_acc + rst_at) begin
        rst = 1'b1;
        hid_finished = 1'b0;
        out_finished = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        m_acc = -100; m_hid = -100; m_out = -100; m_rv = -100; m_hs = -100;
        idle(2);
        rst = 1'b0;
        return;
      end
      hid_finished  = (c == hf_cyc) || (late_hf >= 0 && c == m_rv + late_hf);
      out_finished  = (c == of_cyc);
      bus.rsp_ready = (c == m_hs);
      if (lit_cls >= 0 && c == m_rv) begin
        @(negedge clk);
        check("lit_rsp_valid", bus.rsp_valid, 1);
        check("lit_rsp_class", bus.rsp_class, lit_cls);
        check("lit_rsp_max", bus.rsp_max, lit_max);
        check("lit_rsp_err", bus.rsp_err, lit_err);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    hid_finished  = 1'b0;
    out_finished  = 1'b0;
    foreach (logits[i]) logits[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", bus.req_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_hid_start", hid_start, 0);
    check("reset_out_start", out_start, 0);
    check("reset_rsp_err", bus.rsp_err, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // Nominal: ties at 7 resolve to index 2; latency 2+20+1+20+9+1 = 53.
    lv = '{-5, 3, 7, 2, 7, -1, 0, 0, 0, 6};
    set_logits(lv);
    do_txn(20, 20, 0, 0, -1, -1, 2, 7, 0);
`ifdef MLP_CTRL_PERF_EN
    @(negedge clk);
    check("lit_perf_cycles", perf_cycles, 53);
`endif
    idle(2);

    // All negative, maximum in the last slot.
    foreach (lv[i]) lv[i] = -100;
    lv[9] = -1;
    set_logits(lv);
    do_txn(5, 7, 0, 0, -1, -1, 9, -1, 0);
    idle(1);

    // All equal, fastest cores.
    foreach (lv[i]) lv[i] = 42;
    set_logits(lv);
    do_txn(1, 1, 0, 0, -1, -1, 0, 42, 0);
    idle(1);

    // Backpressure 15 cycles with a request held; it is taken right after the handshake.
    lv = '{3, -8, 12, 12, -40, 5, 11, 0, -1, 2};
    set_logits(lv);
    do_txn(3, 4, 15, 1, -1, -1, 2, 12, 0);
    lv = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
    set_logits(lv);
    do_txn(2, 2, 0, 0, -1, -1, 0, -1, 0);
    idle(2);

    // Hidden core hangs; a late hid_finished in RESP and one in IDLE are ignored.
    do_txn(-1, 0, 5, 0, 2, -1, 0, 0, 1);
    hid_finished = 1'b1;
    idle(1);
    hid_finished = 1'b0;
    idle(2);

    // Output core hangs.
    do_txn(4, -1, 0, 0, -1, -1, 0, 0, 1);
    idle(1);

    // hid_finished exactly on the expiry cycle wins.
    lv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 5};
    set_logits(lv);
    do_txn(TO - 1, 3, 0, 0, -1, -1, 9, 5, 0);
    idle(1);

    // Reset for two cycles while the output core runs, then a normal request.
    lv = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    set_logits(lv);
    do_txn(20, 20, 0, 0, -1, 30, -1, 0, 0);
    @(negedge clk);
    check("post_reset_busy", busy, 0);
    check("post_reset_req_ready", bus.req_ready, 1);
    idle(2);
    do_txn(6, 6, 2, 0, -1, -1, 9, 10, 0);
    idle(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "bench time limit reached");
  end

endmodule
